// File: rtl/vram_port_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : vram_port_scheduler
// Brief   : Shares one VRAM port between the renderer (always wins) and a
//           FIFO-queued, in-order CPU request stream.
// Revision: 1.0
// ============================================================================
module vram_port_scheduler #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rend_req,
    input  logic [ADDR_W-1:0]        rend_addr,
    output logic [DATA_W-1:0]        rend_q,
    input  logic                     cpu_valid,
    output logic                     cpu_ready,
    input  logic                     cpu_we,
    input  logic [ADDR_W-1:0]        cpu_addr,
    input  logic [DATA_W-1:0]        cpu_wdata,
    output logic                     cpu_rvalid,
    output logic [DATA_W-1:0]        cpu_rdata,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic [DATA_W-1:0]        ram_d,
    output logic                     ram_we,
    input  logic [DATA_W-1:0]        ram_q
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;
    localparam logic [c_LVL_W-1:0] c_FULL = c_LVL_W'(DEPTH);

    logic [ADDR_W-1:0]  r_fifo_addr  [DEPTH];
    logic [DATA_W-1:0]  r_fifo_wdata [DEPTH];
    logic [DEPTH-1:0]   r_fifo_we;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_level;
    logic               r_rd_pend;
    logic               r_rvalid;
    logic [DATA_W-1:0]  r_rdata;

    logic w_push;
    logic w_issue;
    logic w_head_we;

    assign cpu_ready  = (r_level != c_FULL);
    assign w_push     = cpu_valid & cpu_ready;
    assign w_issue    = ~rend_req & (r_level != '0);
    assign w_head_we  = r_fifo_we[r_rd_ptr];

    assign fifo_level = r_level;
    assign rend_q     = ram_q;
    assign cpu_rvalid = r_rvalid;
    assign cpu_rdata  = r_rdata;

    // Renderer has absolute priority; the FIFO head only drives an idle port.
    always_comb begin
        ram_addr = '0;
        ram_d    = '0;
        ram_we   = 1'b0;
        if (rend_req) begin
            ram_addr = rend_addr;
        end else if (w_issue) begin
            ram_addr = r_fifo_addr[r_rd_ptr];
            ram_d    = r_fifo_wdata[r_rd_ptr];
            ram_we   = w_head_we & ~reset;
        end
    end

    // Payload storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr]  <= cpu_addr;
            r_fifo_wdata[r_wr_ptr] <= cpu_wdata;
            r_fifo_we[r_wr_ptr]    <= cpu_we;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_issue})
                2'b10:   r_level <= r_level + c_LVL_W'(1);
                2'b01:   r_level <= r_level - c_LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // RAM data arrives one cycle after the issue; capture it then, pulse next.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_pend <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_rd_pend <= w_issue & ~w_head_we;
            r_rvalid  <= r_rd_pend;
            if (r_rd_pend) begin
                r_rdata <= ram_q;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vram_port_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_vram_port_scheduler
// Brief   : Directed self-checking bench with a behavioural synchronous VRAM.
// Revision: 1.0
// ============================================================================
module tb_vram_port_scheduler;

    logic        clk;
    logic        reset;
    logic        rend_req;
    logic [13:0] rend_addr;
    logic [31:0] rend_q;
    logic        cpu_valid;
    logic        cpu_ready;
    logic        cpu_we;
    logic [13:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic [2:0]  fifo_level;
    logic [13:0] ram_addr;
    logic [31:0] ram_d;
    logic        ram_we;
    logic [31:0] ram_q;

    logic [31:0] mem [0:16383];

    int total = 0;
    int bad   = 0;

    vram_port_scheduler #(.ADDR_W(14), .DATA_W(32), .DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .rend_req   (rend_req),
        .rend_addr  (rend_addr),
        .rend_q     (rend_q),
        .cpu_valid  (cpu_valid),
        .cpu_ready  (cpu_ready),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .fifo_level (fifo_level),
        .ram_addr   (ram_addr),
        .ram_d      (ram_d),
        .ram_we     (ram_we),
        .ram_q      (ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_d;
        ram_q <= mem[ram_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; rend_req = 1'b0; rend_addr = '0;
        cpu_valid = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        tick(); tick();
        #1;
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_ready", 32'(cpu_ready), 32'd1);
        chk("rst_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk("rst_we", 32'(ram_we), 32'd0);
        tick();
        reset = 1'b0;

        // single write
        tick();
        cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0010; cpu_wdata = 32'hDEADBEEF;
        #1; chk("t1_ready", 32'(cpu_ready), 32'd1);
        tick();
        cpu_valid = 1'b0;
        #1;
        chk("t1_we", 32'(ram_we), 32'd1);
        chk("t1_addr", 32'(ram_addr), 32'h0010);
        chk("t1_d", ram_d, 32'hDEADBEEF);
        chk("t1_lvl1", 32'(fifo_level), 32'd1);
        tick(); #1;
        chk("t1_lvl0", 32'(fifo_level), 32'd0);
        chk("t1_we0", 32'(ram_we), 32'd0);

        // renderer holds the port for 10 cycles while 5 writes are offered
        begin
            int k;
            k = 0;
            for (int i = 0; i < 10; i++) begin
                tick();
                rend_req = 1'b1; rend_addr = 14'(14'h1000 + i);
                cpu_valid = 1'b1; cpu_we = 1'b1;
                cpu_addr = 14'(14'h0100 + k); cpu_wdata = 32'(32'hA0 + k);
                #1;
                chk("t2_ready", 32'(cpu_ready), (i < 4) ? 32'd1 : 32'd0);
                chk("t2_we", 32'(ram_we), 32'd0);
                chk("t2_raddr", 32'(ram_addr), 32'(14'h1000 + i));
                if (i < 4) k++;
            end
            chk("t2_full", 32'(fifo_level), 32'd4);
            for (int i = 0; i < 5; i++) begin
                tick();
                rend_req = 1'b0; rend_addr = '0;
                cpu_valid = (i <= 1);
                cpu_addr = 14'h0104; cpu_wdata = 32'hA4;
                #1;
                chk("t2_iwe", 32'(ram_we), 32'd1);
                chk("t2_iaddr", 32'(ram_addr), 32'(14'h0100 + i));
                chk("t2_id", ram_d, 32'(32'hA0 + i));
                if (i == 0) chk("t2_rdy0", 32'(cpu_ready), 32'd0);
                if (i == 1) chk("t2_rdy1", 32'(cpu_ready), 32'd1);
            end
            tick(); #1;
            chk("t2_empty", 32'(fifo_level), 32'd0);
            chk("t2_we0", 32'(ram_we), 32'd0);
        end

        // write then read back the same word
        tick();
        cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0123; cpu_wdata = 32'hCAFEF00D;
        tick();
        cpu_we = 1'b0; cpu_wdata = 32'h0;
        #1;
        chk("t3_wwe", 32'(ram_we), 32'd1);
        chk("t3_waddr", 32'(ram_addr), 32'h0123);
        tick();
        cpu_valid = 1'b0;
        #1;
        chk("t3_rwe", 32'(ram_we), 32'd0);
        chk("t3_raddr", 32'(ram_addr), 32'h0123);
        tick(); #1;
        chk("t3_rv_c3", 32'(cpu_rvalid), 32'd0);
        chk("t3_rendq", rend_q, 32'hCAFEF00D);
        tick(); #1;
        chk("t3_rv_c4", 32'(cpu_rvalid), 32'd1);
        chk("t3_rdata", cpu_rdata, 32'hCAFEF00D);
        tick(); #1;
        chk("t3_rv_c5", 32'(cpu_rvalid), 32'd0);
        chk("t3_hold", cpu_rdata, 32'hCAFEF00D);

        // renderer alternates; six writes trickle through on free cycles
        for (int j = 0; j < 13; j++) begin
            tick();
            rend_req = (j % 2 == 0); rend_addr = 14'(14'h3000 + j);
            cpu_valid = (j < 6); cpu_we = 1'b1;
            cpu_addr = 14'(14'h0200 + j); cpu_wdata = 32'(32'hB00 + j);
            #1;
            if (j % 2 == 0) begin
                chk("t4_rwe", 32'(ram_we), 32'd0);
                chk("t4_raddr", 32'(ram_addr), 32'(14'h3000 + j));
            end else begin
                chk("t4_cwe", 32'(ram_we), 32'd1);
                chk("t4_caddr", 32'(ram_addr), 32'(14'h0200 + (j - 1) / 2));
                chk("t4_cd", ram_d, 32'(32'hB00 + (j - 1) / 2));
            end
        end
        tick();
        rend_req = 1'b0; rend_addr = '0; cpu_valid = 1'b0;
        #1; chk("t4_empty", 32'(fifo_level), 32'd0);

        // push and pop in the same cycle at level 2
        tick();
        rend_req = 1'b1; cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0050; cpu_wdata = 32'hC0;
        tick();
        cpu_addr = 14'h0051; cpu_wdata = 32'hC1;
        tick();
        rend_req = 1'b0; cpu_addr = 14'h0052; cpu_wdata = 32'hC2;
        #1;
        chk("t5_lvl_a", 32'(fifo_level), 32'd2);
        chk("t5_addr_a", 32'(ram_addr), 32'h0050);
        tick();
        cpu_valid = 1'b0;
        #1;
        chk("t5_lvl_b", 32'(fifo_level), 32'd2);
        chk("t5_addr_b", 32'(ram_addr), 32'h0051);
        chk("t5_d_b", ram_d, 32'hC1);
        tick(); #1;
        chk("t5_addr_c", 32'(ram_addr), 32'h0052);
        chk("t5_lvl_c", 32'(fifo_level), 32'd1);
        tick(); #1;
        chk("t5_empty", 32'(fifo_level), 32'd0);

        // reset with three queued entries and a read in flight
        tick();
        rend_req = 1'b1; cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0060; cpu_wdata = 32'h0;
        tick();
        cpu_we = 1'b1; cpu_addr = 14'h0061; cpu_wdata = 32'hD1;
        tick();
        cpu_addr = 14'h0062; cpu_wdata = 32'hD2;
        tick();
        rend_req = 1'b0; cpu_addr = 14'h0063; cpu_wdata = 32'hD3;
        #1;
        chk("t6_rd_issue", 32'(ram_addr), 32'h0060);
        chk("t6_rd_we", 32'(ram_we), 32'd0);
        chk("t6_lvl3", 32'(fifo_level), 32'd3);
        tick();
        reset = 1'b1; cpu_valid = 1'b0;
        #1;
        chk("t6_rst_we", 32'(ram_we), 32'd0);
        chk("t6_rst_lvl", 32'(fifo_level), 32'd3);
        tick();
        reset = 1'b0;
        #1;
        chk("t6_lvl0", 32'(fifo_level), 32'd0);
        chk("t6_ready", 32'(cpu_ready), 32'd1);
        chk("t6_we0", 32'(ram_we), 32'd0);
        chk("t6_rv0", 32'(cpu_rvalid), 32'd0);
        chk("t6_rdata0", cpu_rdata, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            chk("t6_no_rv", 32'(cpu_rvalid), 32'd0);
            chk("t6_no_we", 32'(ram_we), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
